// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: round-robin arbiter with registered one-hot grant held until ack.
// Optional feature macro RR_ARB_PERF_CNT_EN adds a saturating accepted-grant counter.  Rev 1.0
`default_nettype none

module rr_grant_arbiter #(
  parameter int WIDTH = 8,
  parameter int PTR_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] req,
  input  logic             ack,
  output logic [WIDTH-1:0] gnt_onehot,
  output logic             gnt_valid
`ifdef RR_ARB_PERF_CNT_EN
  ,
  output logic [15:0]      grant_count
`endif
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state, next_state;
  logic [PTR_W-1:0]   ptr, next_ptr;
  logic [WIDTH-1:0]   next_gnt;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   inc_ptr;
  logic [PTR_W-1:0]   search_base;
  logic [WIDTH-1:0]   cand;
  logic [WIDTH-1:0]   sel_vec;
  logic               sel_found;
  logic               accept;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt_onehot <= '0;
    end else begin
      state      <= next_state;
      ptr        <= next_ptr;
      gnt_onehot <= next_gnt;
    end
  end

  assign gnt_valid = (state == GRANT);
  assign accept    = (state == GRANT) && ack;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (gnt_onehot[i]) gnt_idx = PTR_W'(i);
    end
    inc_ptr = (gnt_idx == PTR_W'(WIDTH - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Idle searches from the stored pointer; an accept searches from the
  // advanced pointer with the just-served requester excluded.
  always_comb begin
    if (state == GRANT) begin
      search_base = inc_ptr;
      cand        = req & ~gnt_onehot;
    end else begin
      search_base = ptr;
      cand        = req;
    end
  end

  always_comb begin
    int idx;
    sel_vec   = '0;
    sel_found = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      idx = int'(search_base) + k;
      if (idx >= WIDTH) idx = idx - WIDTH;
      if (!sel_found && cand[idx]) begin
        sel_vec[idx] = 1'b1;
        sel_found    = 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    next_ptr   = ptr;
    next_gnt   = gnt_onehot;
    case (state)
      IDLE: begin
        if (sel_found) begin
          next_gnt   = sel_vec;
          next_state = GRANT;
        end
      end
      GRANT: begin
        if (ack) begin
          next_ptr = inc_ptr;
          if (sel_found) begin
            next_gnt = sel_vec;
          end else begin
            next_gnt   = '0;
            next_state = IDLE;
          end
        end
      end
      default: begin
        next_state = IDLE;
        next_gnt   = '0;
      end
    endcase
  end

`ifdef RR_ARB_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_count <= '0;
    end else if (accept && (grant_count != 16'hFFFF)) begin
      grant_count <= grant_count + 16'd1;
    end
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

`default_nettype wire
